// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, load extraction, writeback select and the
// retired-instruction counter for the five-stage core.
module writeback_stage #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_load_data,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_wb_sel,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic [4:0]  addr_rd,
    output logic [31:0] data_rd,
    output logic        write_enable,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [63:0] instret
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] alu_q;
    logic [31:0] load_q;
    logic [2:0]  funct3_q;
    logic [1:0]  wb_sel_q;
    logic [4:0]  rd_q;
    logic        reg_write_q;
    logic [63:0] instret_q;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic [31:0] wb_value;

    // Stage register: flush drops the instruction, stall holds, otherwise load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= RESET_PC;
            alu_q       <= 32'd0;
            load_q      <= 32'd0;
            funct3_q    <= 3'd0;
            wb_sel_q    <= 2'd0;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            // Payload fields are don't-care once valid is cleared; leave them.
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= in_valid;
            pc_q        <= in_pc;
            alu_q       <= in_alu_result;
            load_q      <= in_load_data;
            funct3_q    <= in_funct3;
            wb_sel_q    <= in_wb_sel;
            rd_q        <= in_rd;
            reg_write_q <= in_reg_write;
        end
    end

    // Count an instruction when it leaves the stage, including via flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret_q <= 64'd0;
        end else if (valid_q && !stall) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    // Byte/halfword lane selection from the registered load address.
    always_comb begin
        ld_byte = load_q[7:0];
        unique case (alu_q[1:0])
            2'd0: ld_byte = load_q[7:0];
            2'd1: ld_byte = load_q[15:8];
            2'd2: ld_byte = load_q[23:16];
            2'd3: ld_byte = load_q[31:24];
            default: ld_byte = load_q[7:0];
        endcase
        ld_half = alu_q[1] ? load_q[31:16] : load_q[15:0];
        case (funct3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {24'd0, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_value = {16'd0, ld_half};
            default: ld_value = load_q;
        endcase
    end

    // Writeback value select; reserved encoding writes zero.
    always_comb begin
        case (wb_sel_q)
            SEL_ALU:  wb_value = alu_q;
            SEL_LOAD: wb_value = ld_value;
            SEL_PC4:  wb_value = pc_q + 32'd4;
            default:  wb_value = 32'd0;
        endcase
    end

    // Register file port and status outputs, all from registered state.
    always_comb begin
        addr_rd      = valid_q ? rd_q : 5'd0;
        data_rd      = valid_q ? wb_value : 32'd0;
        write_enable = valid_q & reg_write_q & (rd_q != 5'd0);
        wb_valid     = valid_q;
        wb_pc        = pc_q;
        instret      = instret_q;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the five-stage core.
- Captures the memory-stage result each cycle.
- Extracts and extends load data, then selects the writeback value.
- Drives the register file write port (addr_rd, data_rd, write_enable) directly.
- Also keeps a 64-bit retired-instruction counter.

Parameters:
- RESET_PC, 32'h0100_0000, value of wb_pc while reset is asserted and after reset.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold stage register contents
- flush  input  1  load a bubble into the stage register
- in_valid  input  1  memory stage holds a real instruction
- in_pc  input  32  PC of the incoming instruction
- in_alu_result  input  32  ALU result; also the load address
- in_load_data  input  32  raw aligned word read from data memory
- in_funct3  input  3  load width/sign code
- in_wb_sel  input  2  00 = ALU, 01 = load, 10 = PC+4, 11 = reserved
- in_rd  input  5  destination register index
- in_reg_write  input  1  instruction writes rd
- addr_rd  output  5  register file write index
- data_rd  output  32  register file write data
- write_enable  output  1  register file write strobe
- wb_valid  output  1  stage holds a real instruction
- wb_pc  output  32  PC of the instruction in the stage
- instret  output  64  retired-instruction count

Behaviour:
- Stage register holds: valid, pc, alu_result, load_data, funct3, wb_sel, rd, reg_write.
  - Updated on the rising clock edge.
  - Reset is asynchronous: every field clears to 0, except pc, which becomes RESET_PC.
- Per-edge update priority:
  - flush: valid <= 0; other fields are don't-care. Flush overrides stall.
  - else stall: all fields hold.
  - else: all fields load from the in_* ports.
- All outputs are combinational from the stage register only. Latency is one cycle from inputs to outputs. No input reaches an output combinationally.
- Reset values while reset is asserted:
  - addr_rd = 0, data_rd = 0, write_enable = 0, wb_valid = 0
  - wb_pc = RESET_PC, instret = 0
- Load extraction uses the registered off = alu_result[1:0]:
  - funct3 000 (LB): byte at off, sign-extended.
  - funct3 100 (LBU): byte at off, zero-extended.
  - funct3 001 (LH): halfword at off[1], sign-extended; off[0] is ignored.
  - funct3 101 (LHU): halfword at off[1], zero-extended; off[0] is ignored.
  - funct3 010 and all other codes: full word.
  - Byte lanes are little-endian: byte 0 = bits [7:0].
- Writeback select:
  - 00: data_rd = alu_result
  - 01: data_rd = extracted load value
  - 10: data_rd = pc + 4, modulo 2^32 (32'hFFFF_FFFC + 4 = 0)
  - 11: data_rd = 0
- write_enable = valid & reg_write & (rd != 0).
  - Never asserted for x0.
  - Stays asserted during a stall; the repeated write is idempotent.
- addr_rd = rd whenever valid, else 0. data_rd = 0 when valid = 0.
- wb_valid = valid; wb_pc = pc.
- instret:
  - Increments by 1 at a clock edge where valid = 1 and stall = 0, i.e. the instruction leaves the stage.
  - A flush edge with valid = 1 and stall = 0 still counts, because the held instruction retires.
  - A stall edge does not count.
  - Wraps from 2^64-1 to 0.
  - instret is never cleared except by reset.
- Reset asserted mid-operation: the in-flight instruction is dropped and write_enable falls immediately (asynchronously).
- Simultaneous stall and flush: flush wins. instret does not count that edge, since stall = 1.

Test Plan:
- Reset checks:
  - Assert reset mid-run with write_enable = 1 -> write_enable drops to 0 before the next clock edge.
  - After release -> wb_pc = 32'h0100_0000, instret = 0.
- ALU writeback: in_valid = 1, wb_sel = 00, alu_result = 32'hDEAD_BEEF, rd = 5, reg_write = 1 -> next cycle addr_rd = 5, data_rd = 32'hDEAD_BEEF, write_enable = 1. Same with rd = 0 -> write_enable = 0.
- Loads with load_data = 32'h8070_F0A1:
  - LB off 0 -> 32'hFFFF_FFA1
  - LBU off 2 -> 32'h0000_0070
  - LH off 2 -> 32'hFFFF_8070
  - LHU off 3 -> 32'h0000_8070
  - LW -> 32'h8070_F0A1
- PC+4 select: pc = 32'h0000_1000 -> data_rd = 32'h0000_1004. pc = 32'hFFFF_FFFC -> data_rd = 0.
- Stall/flush sequencing:
  - Three valid instructions with stall held for 2 cycles on the second -> outputs hold during the stall, and instret ends at 3.
  - Stall and flush together -> wb_valid = 0 next cycle, and instret unchanged on that edge.
- Counter wrap: run 10 valid, unstalled instructions -> instret = 10. Force instret to 2^64-1 (via hierarchical deposit), retire one more -> instret = 0.
